// File: rtl/solver_control_mc_if.sv
// Host load, datapath control/status and result handshake signals of solver_control_mc.
// slave = the sequencer, master = the host/datapath side driving it.
interface solver_control_mc_if #(
    parameter int LIMB_INDEX_BITS = 6,
    parameter int ITER_BITS       = 16
);
    logic                       wr_real_en;
    logic                       wr_imag_en;
    logic [LIMB_INDEX_BITS-1:0] wr_ind;
    logic                       wr_num_limbs_en;
    logic [LIMB_INDEX_BITS-1:0] num_limbs_data;
    logic                       wr_iter_lim_en;
    logic [ITER_BITS-1:0]       iter_lim_data;
    logic                       start;
    logic                       mode;
    logic                       abort;
    logic                       diverged;
    logic                       zre_sign;
    logic                       zim_sign;
    logic [LIMB_INDEX_BITS-1:0] limb_ind;
    logic [LIMB_INDEX_BITS-1:0] zre_ind;
    logic [LIMB_INDEX_BITS-1:0] zim_ind;
    logic                       cre_wr_en;
    logic                       cim_wr_en;
    logic                       zre_wr_en;
    logic                       zim_wr_en;
    logic                       op_abs;
    logic                       flip;
    logic                       first_part;
    logic                       top_limb;
    logic                       neg_im;
    logic                       res_valid;
    logic                       res_ready;
    logic [ITER_BITS-1:0]       res_count;
    logic                       busy;

    modport slave (
        input  wr_real_en, wr_imag_en, wr_ind, wr_num_limbs_en, num_limbs_data,
               wr_iter_lim_en, iter_lim_data, start, mode, abort,
               diverged, zre_sign, zim_sign, res_ready,
        output limb_ind, zre_ind, zim_ind, cre_wr_en, cim_wr_en, zre_wr_en, zim_wr_en,
               op_abs, flip, first_part, top_limb, neg_im, res_valid, res_count, busy
    );

    modport master (
        output wr_real_en, wr_imag_en, wr_ind, wr_num_limbs_en, num_limbs_data,
               wr_iter_lim_en, iter_lim_data, start, mode, abort,
               diverged, zre_sign, zim_sign, res_ready,
        input  limb_ind, zre_ind, zim_ind, cre_wr_en, cim_wr_en, zre_wr_en, zim_wr_en,
               op_abs, flip, first_part, top_limb, neg_im, res_valid, res_count, busy
    );
endinterface

// File: rtl/solver_control_mc.sv
// Limb / partial-product sequencer for the multi-limb escape-time solver (z = z^2 + c).
// Define SOLVER_ABS_EN to build the Burning Ship |z| pass (ABS/ABS_FLUSH, mode, neg_im).
module solver_control_mc #(
    parameter int LIMB_INDEX_BITS = 6,
    parameter int ITER_BITS       = 16,
    parameter int FLUSH_WAIT      = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    solver_control_mc_if.slave bus
);
    localparam int FLUSH_BITS = (FLUSH_WAIT > 0) ? $clog2(FLUSH_WAIT + 1) : 1;
    localparam logic [FLUSH_BITS-1:0]      FLUSH_LAST = FLUSH_BITS'(FLUSH_WAIT);
    localparam logic [LIMB_INDEX_BITS-1:0] LIMB_ONE   = LIMB_INDEX_BITS'(1);
    localparam logic [ITER_BITS-1:0]       ITER_ONE   = ITER_BITS'(1);

`ifdef SOLVER_ABS_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ABS, S_ABS_FLUSH, S_ITER, S_ITER_FLUSH, S_CHECK, S_DONE
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ITER, S_ITER_FLUSH, S_CHECK, S_DONE
    } state_e;
`endif

    state_e                     state_q, state_d;
    logic [LIMB_INDEX_BITS-1:0] limb_q, limb_d;
    logic [LIMB_INDEX_BITS-1:0] part_q, part_d;
    logic                       flip_q, flip_d;
    logic [FLUSH_BITS-1:0]      flushCnt_q, flushCnt_d;
    logic [ITER_BITS-1:0]       iterCount_q, iterCount_d;
    logic [LIMB_INDEX_BITS-1:0] numLimbs_q, numLimbs_d;
    logic [ITER_BITS-1:0]       iterLim_q, iterLim_d;
    logic                       resValid_q, resValid_d;
    logic [ITER_BITS-1:0]       resCount_q, resCount_d;
`ifdef SOLVER_ABS_EN
    logic                       mode_q, mode_d;
    logic                       negIm_q, negIm_d;
`else
    logic                       unusedAbsInputs;
    assign unusedAbsInputs = ^{bus.mode, bus.zre_sign, bus.zim_sign};
`endif

    logic [LIMB_INDEX_BITS-1:0] topIdx;
    logic [LIMB_INDEX_BITS-1:0] halfLimb;
    logic [LIMB_INDEX_BITS-1:0] numLimbsWr;
    logic [LIMB_INDEX_BITS-1:0] numLimbsEff;
    logic                       busyNow;

    assign topIdx      = numLimbs_q - LIMB_ONE;
    assign halfLimb    = limb_q >> 1;
    assign numLimbsWr  = (bus.num_limbs_data == '0) ? LIMB_ONE : bus.num_limbs_data;
    // A limb-count write in the start cycle must already shape the first pass.
    assign numLimbsEff = bus.wr_num_limbs_en ? numLimbsWr : numLimbs_q;
    assign busyNow     = (state_q != S_IDLE) && (state_q != S_DONE);

    assign bus.busy      = busyNow;
    assign bus.res_valid = resValid_q;
    assign bus.res_count = resCount_q;
`ifdef SOLVER_ABS_EN
    assign bus.neg_im    = negIm_q;
`else
    assign bus.neg_im    = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            limb_q      <= '0;
            part_q      <= '0;
            flip_q      <= 1'b0;
            flushCnt_q  <= '0;
            iterCount_q <= '0;
            numLimbs_q  <= LIMB_ONE;
            iterLim_q   <= '0;
            resValid_q  <= 1'b0;
            resCount_q  <= '0;
`ifdef SOLVER_ABS_EN
            mode_q      <= 1'b0;
            negIm_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            limb_q      <= limb_d;
            part_q      <= part_d;
            flip_q      <= flip_d;
            flushCnt_q  <= flushCnt_d;
            iterCount_q <= iterCount_d;
            numLimbs_q  <= numLimbs_d;
            iterLim_q   <= iterLim_d;
            resValid_q  <= resValid_d;
            resCount_q  <= resCount_d;
`ifdef SOLVER_ABS_EN
            mode_q      <= mode_d;
            negIm_q     <= negIm_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        limb_d         = limb_q;
        part_d         = part_q;
        flip_d         = flip_q;
        flushCnt_d     = flushCnt_q;
        iterCount_d    = iterCount_q;
        numLimbs_d     = numLimbs_q;
        iterLim_d      = iterLim_q;
        resValid_d     = resValid_q;
        resCount_d     = resCount_q;
`ifdef SOLVER_ABS_EN
        mode_d         = mode_q;
        negIm_d        = negIm_q;
`endif
        bus.limb_ind   = limb_q;
        bus.zre_ind    = '0;
        bus.zim_ind    = '0;
        bus.cre_wr_en  = 1'b0;
        bus.cim_wr_en  = 1'b0;
        bus.zre_wr_en  = 1'b0;
        bus.zim_wr_en  = 1'b0;
        bus.op_abs     = 1'b0;
        bus.flip       = 1'b0;
        bus.first_part = 1'b0;
        bus.top_limb   = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.cre_wr_en = bus.wr_real_en;
                bus.cim_wr_en = bus.wr_imag_en;
                bus.limb_ind  = bus.wr_ind;
                if (bus.wr_num_limbs_en) numLimbs_d = numLimbsWr;
                if (bus.wr_iter_lim_en)  iterLim_d  = bus.iter_lim_data;
                if (bus.start) begin
                    iterCount_d = '0;
                    limb_d      = numLimbsEff - LIMB_ONE;
                    part_d      = '0;
                    flip_d      = 1'b0;
`ifdef SOLVER_ABS_EN
                    mode_d      = bus.mode;
                    negIm_d     = 1'b0;
                    state_d     = bus.mode ? S_ABS : S_ITER;
`else
                    state_d     = S_ITER;
`endif
                end
            end
`ifdef SOLVER_ABS_EN
            S_ABS: begin
                bus.op_abs    = 1'b1;
                bus.zre_ind   = limb_q;
                bus.zim_ind   = limb_q;
                bus.zre_wr_en = !bus.abort;
                bus.zim_wr_en = !bus.abort;
                bus.top_limb  = (limb_q == topIdx);
                if (limb_q == '0) begin
                    state_d    = S_ABS_FLUSH;
                    flushCnt_d = '0;
                end else begin
                    limb_d = limb_q - LIMB_ONE;
                end
            end
            S_ABS_FLUSH: begin
                if (flushCnt_q == FLUSH_LAST) begin
                    state_d = S_ITER;
                    limb_d  = topIdx;
                    part_d  = '0;
                    flip_d  = 1'b0;
                end else begin
                    flushCnt_d = flushCnt_q + 1'b1;
                end
            end
`endif
            S_ITER: begin
                bus.flip       = flip_q;
                bus.first_part = (part_q == '0);
                bus.top_limb   = (limb_q == topIdx);
                bus.zre_ind    = flip_q ? part_q : limb_q - part_q;
                bus.zim_ind    = flip_q ? limb_q - part_q : part_q;
                if (!flip_q) begin
                    flip_d = 1'b1;
                end else if (part_q != halfLimb) begin
                    part_d = part_q + LIMB_ONE;
                    flip_d = 1'b0;
                end else begin
                    // Last partial of this limb: the accumulated result is written back.
                    bus.zre_wr_en = !bus.abort;
                    bus.zim_wr_en = !bus.abort;
                    part_d        = '0;
                    flip_d        = 1'b0;
                    if (limb_q == '0) begin
                        state_d    = S_ITER_FLUSH;
                        flushCnt_d = '0;
                    end else begin
                        limb_d = limb_q - LIMB_ONE;
                    end
                end
            end
            S_ITER_FLUSH: begin
                if (flushCnt_q == FLUSH_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    flushCnt_d = flushCnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (bus.diverged) begin
                    resCount_d = iterCount_q;
                    resValid_d = 1'b1;
                    state_d    = S_DONE;
                end else if (iterCount_q == iterLim_q) begin
                    resCount_d = '1;
                    resValid_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    iterCount_d = iterCount_q + ITER_ONE;
                    limb_d      = topIdx;
                    part_d      = '0;
                    flip_d      = 1'b0;
`ifdef SOLVER_ABS_EN
                    if (mode_q) negIm_d = bus.zre_sign ^ bus.zim_sign;
                    state_d = mode_q ? S_ABS : S_ITER;
`else
                    state_d = S_ITER;
`endif
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    resValid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort discards the solve: nothing latched in this cycle survives.
        if (bus.abort && busyNow) begin
            state_d     = S_IDLE;
            iterCount_d = iterCount_q;
            resValid_d  = resValid_q;
            resCount_d  = resCount_q;
`ifdef SOLVER_ABS_EN
            negIm_d     = negIm_q;
`endif
        end
    end
endmodule

// File: tb/tb_solver_control_mc.sv
// Self-checking bench for solver_control_mc: a schedule-level model checked every cycle,
// plus directed solves with hand-computed latencies, addresses and result counts.
module tb_solver_control_mc;
    localparam int LB = 6;
    localparam int IB = 16;
    localparam int FW = 4;
`ifdef SOLVER_ABS_EN
    localparam bit ABS_EN = 1'b1;
`else
    localparam bit ABS_EN = 1'b0;
`endif

    typedef enum int {K_IDLE, K_ABS, K_ABSF, K_ITER, K_ITERF, K_CHECK, K_DONE} kind_e;
    typedef struct {
        kind_e kind;
        int    l;
        int    p;
        int    f;
    } step_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    solver_control_mc_if #(.LIMB_INDEX_BITS(LB), .ITER_BITS(IB)) bus ();

    solver_control_mc #(
        .LIMB_INDEX_BITS(LB),
        .ITER_BITS      (IB),
        .FLUSH_WAIT     (FW)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int    assertCount = 0;
    int    failCount   = 0;
    bit    checkEn     = 1'b0;
    step_t cur = '{kind: K_IDLE, l: 0, p: 0, f: 0};
    step_t sched[$];
    int    mN = 1, mLim = 0, mCount = 0, mRes = 0;
    bit    mMode = 1'b0, mNeg = 1'b0, mValid = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // One full pass of the schedule, expanded from the nested limb/partial/flip loops.
    function automatic void buildPass();
        if (mMode) begin
            for (int l = mN - 1; l >= 0; l--) sched.push_back('{kind: K_ABS, l: l, p: 0, f: 0});
            for (int i = 0; i <= FW; i++) sched.push_back('{kind: K_ABSF, l: 0, p: 0, f: 0});
        end
        for (int l = mN - 1; l >= 0; l--)
            for (int p = 0; p <= l / 2; p++)
                for (int f = 0; f < 2; f++)
                    sched.push_back('{kind: K_ITER, l: l, p: p, f: f});
        for (int i = 0; i <= FW; i++) sched.push_back('{kind: K_ITERF, l: 0, p: 0, f: 0});
        sched.push_back('{kind: K_CHECK, l: 0, p: 0, f: 0});
    endfunction

    task automatic compareAll();
        logic expBusy, expWr;
        expBusy = (cur.kind != K_IDLE) && (cur.kind != K_DONE);
        expWr   = ((cur.kind == K_ABS) ||
                   (cur.kind == K_ITER && cur.f == 1 && cur.p == cur.l / 2)) && !bus.abort;
        checkOutput("busy", bus.busy, expBusy);
        checkOutput("res_valid", bus.res_valid, mValid);
        checkOutput("res_count", bus.res_count, mRes);
        checkOutput("neg_im", bus.neg_im, mNeg);
        checkOutput("op_abs", bus.op_abs, cur.kind == K_ABS);
        checkOutput("zre_wr_en", bus.zre_wr_en, expWr);
        checkOutput("zim_wr_en", bus.zim_wr_en, expWr);
        checkOutput("cre_wr_en", bus.cre_wr_en, (cur.kind == K_IDLE) && bus.wr_real_en);
        checkOutput("cim_wr_en", bus.cim_wr_en, (cur.kind == K_IDLE) && bus.wr_imag_en);
        if (cur.kind == K_IDLE) checkOutput("limb_ind", bus.limb_ind, bus.wr_ind);
        if (cur.kind == K_ABS) begin
            checkOutput("abs zre_ind", bus.zre_ind, cur.l);
            checkOutput("abs zim_ind", bus.zim_ind, cur.l);
            checkOutput("top_limb", bus.top_limb, cur.l == mN - 1);
        end
        if (cur.kind == K_ITER) begin
            checkOutput("iter zre_ind", bus.zre_ind, cur.f ? cur.p : cur.l - cur.p);
            checkOutput("iter zim_ind", bus.zim_ind, cur.f ? cur.l - cur.p : cur.p);
            checkOutput("flip", bus.flip, cur.f);
            checkOutput("first_part", bus.first_part, cur.p == 0);
        end
    endtask

    task automatic modelStep();
        if (!reset_n) begin
            sched.delete();
            cur = '{kind: K_IDLE, l: 0, p: 0, f: 0};
            mN = 1; mLim = 0; mCount = 0; mRes = 0;
            mMode = 1'b0; mNeg = 1'b0; mValid = 1'b0;
            return;
        end
        case (cur.kind)
            K_IDLE: begin
                if (bus.wr_num_limbs_en) mN = (bus.num_limbs_data == 0) ? 1 : int'(bus.num_limbs_data);
                if (bus.wr_iter_lim_en) mLim = int'(bus.iter_lim_data);
                if (bus.start) begin
                    mMode  = ABS_EN && bus.mode;
                    mCount = 0;
                    mNeg   = 1'b0;
                    buildPass();
                    cur = sched.pop_front();
                end
            end
            K_DONE: begin
                if (bus.res_ready) begin
                    mValid   = 1'b0;
                    cur.kind = K_IDLE;
                end
            end
            default: begin
                if (bus.abort) begin
                    sched.delete();
                    cur = '{kind: K_IDLE, l: 0, p: 0, f: 0};
                end else if (cur.kind == K_CHECK) begin
                    if (bus.diverged) begin
                        mRes = mCount; mValid = 1'b1; cur.kind = K_DONE;
                    end else if (mCount == mLim) begin
                        mRes = (1 << IB) - 1; mValid = 1'b1; cur.kind = K_DONE;
                    end else begin
                        mCount++;
                        if (mMode) mNeg = bus.zre_sign ^ bus.zim_sign;
                        buildPass();
                        cur = sched.pop_front();
                    end
                end else begin
                    cur = sched.pop_front();
                end
            end
        endcase
    endtask

    always @(negedge clock) begin
        if (checkEn) compareAll();
        modelStep();
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives one start cycle (with optional same-cycle writes); returns in cycle 1 of the solve.
    task automatic applyStimulus(input bit wrN, input int nData, input bit wrLim, input int limData, input bit md);
        bus.wr_num_limbs_en = wrN;
        bus.num_limbs_data  = LB'(nData);
        bus.wr_iter_lim_en  = wrLim;
        bus.iter_lim_data   = IB'(limData);
        bus.mode            = md;
        bus.start           = 1'b1;
        tick();
        bus.wr_num_limbs_en = 1'b0;
        bus.wr_iter_lim_en  = 1'b0;
        bus.start           = 1'b0;
        bus.mode            = 1'b0;
    endtask

    task automatic waitResult(input int fromCycle, output int cycles);
        cycles = fromCycle;
        while (bus.res_valid !== 1'b1 && cycles < 3000) begin
            tick();
            cycles++;
        end
        checkOutput("res_valid within budget", bus.res_valid, 1'b1);
    endtask

    task automatic finishResult();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        checkOutput("busy after handshake", bus.busy, 1'b0);
        checkOutput("res_valid after handshake", bus.res_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int zreExp[4] = '{3, 0, 2, 1};
        int zimExp[4] = '{0, 3, 1, 2};
        int absZre[3];
        int absOp;
        int holdCycle;
        int absLat;
`ifdef SOLVER_ABS_EN
        absZre = '{2, 1, 0};
        absOp = 1;
        holdCycle = 30;
        absLat = 45;
`else
        absZre = '{2, 0, 1};
        absOp = 0;
        holdCycle = 20;
        absLat = 29;
`endif
        bus.wr_real_en = 0; bus.wr_imag_en = 0; bus.wr_ind = '0;
        bus.wr_num_limbs_en = 0; bus.num_limbs_data = '0;
        bus.wr_iter_lim_en = 0; bus.iter_lim_data = '0;
        bus.start = 0; bus.mode = 0; bus.abort = 0;
        bus.diverged = 0; bus.zre_sign = 0; bus.zim_sign = 0; bus.res_ready = 0;

        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        checkEn = 1'b1;
        checkOutput("reset busy", bus.busy, 1'b0);
        checkOutput("reset res_valid", bus.res_valid, 1'b0);
        checkOutput("reset res_count", bus.res_count, 16'h0000);
        checkOutput("reset neg_im", bus.neg_im, 1'b0);

        $display("[TB] N=1 limit=5, diverge at first check");
        bus.diverged = 1'b1;
        applyStimulus(1'b1, 1, 1'b1, 5, 1'b0);
        waitResult(1, lat);
        checkOutput("n1 latency", lat, 9);
        checkOutput("n1 res_count", bus.res_count, 16'h0000);
        finishResult();

        $display("[TB] N=4 limit=2, never diverge");
        bus.diverged = 1'b0;
        applyStimulus(1'b1, 4, 1'b1, 2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("L3 zre_ind", bus.zre_ind, zreExp[i]);
            checkOutput("L3 zim_ind", bus.zim_ind, zimExp[i]);
            tick();
        end
        waitResult(5, lat);
        checkOutput("n4 latency", lat, 55);
        checkOutput("n4 res_count", bus.res_count, 16'hFFFF);

        $display("[TB] hold result with res_ready low, start pulsed");
        for (int i = 0; i < 10; i++) begin
            bus.start = (i == 3);
            checkOutput("done res_valid", bus.res_valid, 1'b1);
            checkOutput("done res_count", bus.res_count, 16'hFFFF);
            tick();
        end
        bus.start = 1'b0;
        finishResult();
        tick();
        checkOutput("idle stays idle", bus.busy, 1'b0);

        $display("[TB] N=3 mode 1, diverge at second check");
        bus.zre_sign = 1'b1;
        bus.zim_sign = 1'b0;
        applyStimulus(1'b1, 3, 1'b1, 5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("mode1 zre_ind", bus.zre_ind, absZre[i]);
            checkOutput("mode1 op_abs", bus.op_abs, absOp);
            tick();
        end
        bus.wr_real_en = 1'b1;
        bus.wr_ind = LB'(7);
        repeat (holdCycle - 4) tick();
        bus.wr_real_en = 1'b0;
        checkOutput("second pass neg_im", bus.neg_im, absOp);
        bus.diverged = 1'b1;
        waitResult(holdCycle, lat);
        checkOutput("mode1 latency", lat, absLat);
        checkOutput("mode1 res_count", bus.res_count, 16'h0001);
        finishResult();
        bus.diverged = 1'b0;
        bus.zre_sign = 1'b0;

        $display("[TB] abort in iteration flush");
        applyStimulus(1'b1, 1, 1'b0, 0, 1'b0);
        repeat (3) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checkOutput("abort busy", bus.busy, 1'b0);
        checkOutput("abort res_valid", bus.res_valid, 1'b0);
        repeat (10) tick();
        checkOutput("abort no result", bus.res_valid, 1'b0);

        $display("[TB] reset mid-iteration with start and abort");
        applyStimulus(1'b1, 4, 1'b1, 9, 1'b0);
        repeat (2) tick();
        reset_n = 1'b0;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        reset_n = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checkOutput("mid reset busy", bus.busy, 1'b0);
        checkOutput("mid reset res_valid", bus.res_valid, 1'b0);
        checkOutput("mid reset res_count", bus.res_count, 16'h0000);
        checkOutput("mid reset neg_im", bus.neg_im, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
        waitResult(1, lat);
        checkOutput("post reset latency", lat, 9);
        checkOutput("post reset res_count", bus.res_count, 16'hFFFF);
        finishResult();

        $display("[TB] zero limb count written with start");
        bus.wr_num_limbs_en = 1'b1;
        bus.num_limbs_data = LB'(4);
        bus.wr_imag_en = 1'b1;
        bus.wr_ind = LB'(5);
        tick();
        bus.wr_imag_en = 1'b0;
        bus.diverged = 1'b1;
        applyStimulus(1'b1, 0, 1'b1, 3, 1'b0);
        waitResult(1, lat);
        checkOutput("zero-N latency", lat, 9);
        checkOutput("zero-N res_count", bus.res_count, 16'h0000);
        finishResult();
        bus.diverged = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
